io_host_sequencer: RTL

//  Host-side partner of the processor's Enter/data_in input handshake. Buffers

---
 rtl/io_host_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/io_host_sequencer.sv
// Host-side input sequencer: queues operand bytes and answers processor input requests.
// Optional watchdog on WAIT_REQ/RELEASE enabled by defining IO_HOST_WATCHDOG_EN.
module io_host_sequencer #(
    parameter int DEPTH     = 8,
    parameter int ENTER_CYC = 2
`ifdef IO_HOST_WATCHDOG_EN
    ,
    parameter int TIMEOUT   = 1024
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       start,
    input  logic       CheckState,
    input  logic       Halt,
    input  logic [7:0] dataOut,
    output logic [7:0] data_in,
    output logic       Enter,
    output logic       testStart,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       underflow,
    output logic       timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ENTER_CYC > 1) ? $clog2(ENTER_CYC) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CYC = CW'(ENTER_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_REQ, SETUP, STROBE, RELEASE, DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          lr_q;
    logic          push, pop, empty;
    logic [7:0]    data_in_q, data_in_d;
    logic [7:0]    result_q, result_d;
    logic          enter_q;
    logic          tstart_q, tstart_d;
    logic          rv_q, rv_d;
    logic          uf_q, uf_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          wd_hit;

    assign empty   = (count_q == '0);
    assign push    = load_valid && lr_q;
    assign count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        result_d  = result_q;
        tstart_d  = 1'b0;
        rv_d      = rv_q;
        uf_d      = uf_q;
        cyc_d     = cyc_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    tstart_d = 1'b1;
                    rv_d     = 1'b0;
                    uf_d     = 1'b0;
                    state_d  = WAIT_REQ;
                end
            end
            WAIT_REQ: begin
                if (Halt) begin
                    result_d = dataOut;
                    rv_d     = 1'b1;
                    state_d  = DONE;
                end else if (wd_hit) begin
                    state_d = DONE;
                end else if (CheckState) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        data_in_d = mem_q[rptr_q];
                        state_d   = SETUP;
                    end else begin
                        uf_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                cyc_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cyc_q == LAST_CYC) state_d = RELEASE;
                else cyc_d = cyc_q + 1'b1;
            end
            RELEASE: begin
                if (Halt) begin
                    result_d = dataOut;
                    rv_d     = 1'b1;
                    state_d  = DONE;
                end else if (wd_hit) begin
                    state_d = DONE;
                end else if (!CheckState) begin
                    state_d = WAIT_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push) mem_q[wptr_q] <= load_data;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            lr_q      <= 1'b1;
            data_in_q <= '0;
            result_q  <= '0;
            enter_q   <= 1'b0;
            tstart_q  <= 1'b0;
            rv_q      <= 1'b0;
            uf_q      <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_q + AW'(push);
            rptr_q    <= rptr_q + AW'(pop);
            count_q   <= count_d;
            lr_q      <= (count_d != FULL_CNT);
            data_in_q <= data_in_d;
            result_q  <= result_d;
            enter_q   <= (state_d == STROBE);
            tstart_q  <= tstart_d;
            rv_q      <= rv_d;
            uf_q      <= uf_d;
            cyc_q     <= cyc_d;
        end
    end

`ifdef IO_HOST_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          to_q;
    logic          waiting;

    assign waiting = (state_q == WAIT_REQ) || (state_q == RELEASE);
    assign wd_hit  = waiting && (wd_q == WW'(TIMEOUT - 1));

    // Counter restarts on every state change so each wait is bounded on its own.
    always_comb begin
        wd_d = '0;
        if (waiting && state_d == state_q) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_hit) to_q <= 1'b1;
            else if (tstart_d) to_q <= 1'b0;
        end
    end

    assign timeout = to_q;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign load_ready   = lr_q;
    assign data_in      = data_in_q;
    assign Enter        = enter_q;
    assign testStart    = tstart_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign underflow    = uf_q;
    assign busy         = (state_q != IDLE) && (state_q != DONE);

endmodule
